// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register between two CPU stages, with an optional skid entry.
// An empty stage presents NOP_INSN / PC 0 downstream, so no separate bubble mux is needed.
module pipe_stage_reg #(
  parameter int                DATA_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h00000013),
  parameter bit                SKID     = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_insn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_insn,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  logic              init_q;
  logic              rdy_q, rdy_d;
  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] main_insn_q, main_insn_d;
  logic [DATA_W-1:0] skid_insn_q, skid_insn_d;
  logic [1:0]        occ_q, occ_d;
  logic              push, pop;
  occ_state_e        state;

  assign push  = in_valid & in_ready;
  assign pop   = main_v_q & out_ready;
  assign state = skid_v_q ? FULL : (main_v_q ? ONE : EMPTY);

  generate
    if (SKID) begin : g_skid
      // Ready comes from a flop; only flush may pull it low within the cycle.
      assign in_ready = rdy_q & ~flush;

      always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_pc_d   = main_pc_q;
        main_insn_d = main_insn_q;
        skid_pc_d   = skid_pc_q;
        skid_insn_d = skid_insn_q;
        if (flush) begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end else begin
          unique case (state)
            EMPTY: begin
              if (push) begin
                main_v_d    = 1'b1;
                main_pc_d   = in_pc;
                main_insn_d = in_insn;
              end
            end
            ONE: begin
              if (push && !pop) begin
                skid_v_d    = 1'b1;
                skid_pc_d   = in_pc;
                skid_insn_d = in_insn;
              end else if (push && pop) begin
                main_pc_d   = in_pc;
                main_insn_d = in_insn;
              end else if (pop) begin
                main_v_d = 1'b0;
              end
            end
            FULL: begin
              // in_ready is low here, so any in_valid is ignored.
              if (pop) begin
                main_pc_d   = skid_pc_q;
                main_insn_d = skid_insn_q;
                skid_v_d    = 1'b0;
              end
            end
            default: begin
              main_v_d = 1'b0;
              skid_v_d = 1'b0;
            end
          endcase
        end
      end

      assign rdy_d = ~skid_v_d;
    end else begin : g_single
      assign in_ready = init_q & ~flush & (~main_v_q | out_ready);

      always_comb begin
        main_v_d    = main_v_q;
        main_pc_d   = main_pc_q;
        main_insn_d = main_insn_q;
        skid_v_d    = 1'b0;
        skid_pc_d   = skid_pc_q;
        skid_insn_d = skid_insn_q;
        if (flush) begin
          main_v_d = 1'b0;
        end else if (push) begin
          main_v_d    = 1'b1;
          main_pc_d   = in_pc;
          main_insn_d = in_insn;
        end else if (pop) begin
          main_v_d = 1'b0;
        end
      end

      assign rdy_d = 1'b0;
    end
  endgenerate

  assign occ_d = 2'(main_v_d) + 2'(skid_v_d);

  // Control state: cleared asynchronously; init_q keeps in_ready low for the first cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_q   <= 1'b0;
      rdy_q    <= 1'b0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      init_q   <= 1'b1;
      rdy_q    <= rdy_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      occ_q    <= occ_d;
    end
  end

  // Payload needs no reset: it is only visible through the valid-gated output mux.
  always_ff @(posedge clock) begin
    main_pc_q   <= main_pc_d;
    main_insn_q <= main_insn_d;
    skid_pc_q   <= skid_pc_d;
    skid_insn_q <= skid_insn_d;
  end

  assign out_valid = main_v_q;
  assign out_pc    = main_v_q ? main_pc_q : '0;
  assign out_insn  = main_v_q ? main_insn_q : NOP_INSN;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus, each checked
// every cycle against a queue model, plus literal expectations for the directed scenarios.
module tb_pipe_stage_reg;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_insn = '0;
  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_pc0, out_insn0, out_pc1, out_insn1;
  logic [1:0]  occ0, occ1;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  bit          init_m = 1'b0;

  always #5 clock = ~clock;

  pipe_stage_reg #(.DATA_W(32), .PC_W(32), .NOP_INSN(NOP), .SKID(1'b1)) u_skid (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_pc(in_pc), .in_insn(in_insn), .out_valid(out_valid1), .out_ready(out_ready),
    .out_pc(out_pc1), .out_insn(out_insn1), .occupancy(occ1));

  pipe_stage_reg #(.DATA_W(32), .PC_W(32), .NOP_INSN(NOP), .SKID(1'b0)) u_single (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_pc(in_pc), .in_insn(in_insn), .out_valid(out_valid0), .out_ready(out_ready),
    .out_pc(out_pc0), .out_insn(out_insn0), .occupancy(occ0));

  function automatic bit rdy0_m();
    return init_m && !flush && (q0.size() == 0 || out_ready);
  endfunction

  function automatic bit rdy1_m();
    return init_m && !flush && (q1.size() < 2);
  endfunction

  // Reference model: a FIFO of {pc, insn} per instance, capacity 1 or 2.
  always @(posedge clock or negedge reset_n) begin
    bit p0, p1;
    if (!reset_n) begin
      q0.delete();
      q1.delete();
      init_m = 1'b0;
    end else begin
      p0 = in_valid && rdy0_m();
      p1 = in_valid && rdy1_m();
      if (flush) begin
        q0.delete();
        q1.delete();
      end else begin
        if (q0.size() > 0 && out_ready) void'(q0.pop_front());
        if (q1.size() > 0 && out_ready) void'(q1.pop_front());
        if (p0) q0.push_back({in_pc, in_insn});
        if (p1) q1.push_back({in_pc, in_insn});
      end
      init_m = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [63:0] h0, h1;
    h0 = {32'd0, NOP};
    h1 = {32'd0, NOP};
    if (q0.size() != 0) h0 = q0[0];
    if (q1.size() != 0) h1 = q1[0];
    chk("in_ready0", 64'(in_ready0), 64'(rdy0_m()));
    chk("out_valid0", 64'(out_valid0), 64'(q0.size() != 0));
    chk("out_pc0", 64'(out_pc0), 64'(h0[63:32]));
    chk("out_insn0", 64'(out_insn0), 64'(h0[31:0]));
    chk("occupancy0", 64'(occ0), 64'(q0.size()));
    chk("in_ready1", 64'(in_ready1), 64'(rdy1_m()));
    chk("out_valid1", 64'(out_valid1), 64'(q1.size() != 0));
    chk("out_pc1", 64'(out_pc1), 64'(h1[63:32]));
    chk("out_insn1", 64'(out_insn1), 64'(h1[31:0]));
    chk("occupancy1", 64'(occ1), 64'(q1.size()));
  endtask

  always @(negedge clock) check_all();

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input bit v, input logic [31:0] pc, input bit fl, input bit ordy);
    in_valid  = v;
    in_pc     = pc;
    in_insn   = ~pc;
    flush     = fl;
    out_ready = ordy;
  endtask

  initial begin
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #3;
    chk("t1_reset_insn1", 64'(out_insn1), 64'h13);
    chk("t1_reset_pc0", 64'(out_pc0), 64'h0);
    reset_n = 1'b1;
    #1;
    chk("t1_first_rdy1", 64'(in_ready1), 64'h0);
    chk("t1_first_rdy0", 64'(in_ready0), 64'h0);
    step();
    chk("t1_after_rdy1", 64'(in_ready1), 64'h1);
    chk("t1_after_rdy0", 64'(in_ready0), 64'h1);
    chk("t1_after_insn0", 64'(out_insn0), 64'h13);

    // Streaming with out_ready held high.
    drv(1'b1, 32'h0, 1'b0, 1'b1); step();
    chk("t2_valid1_a", 64'(out_valid1), 64'h1);
    chk("t2_pc1_a", 64'(out_pc1), 64'h0);
    drv(1'b1, 32'h4, 1'b0, 1'b1); step();
    chk("t2_pc1_b", 64'(out_pc1), 64'h4);
    chk("t2_pc0_b", 64'(out_pc0), 64'h4);
    chk("t2_occ1_b", 64'(occ1), 64'h1);
    drv(1'b1, 32'h8, 1'b0, 1'b1); step();
    chk("t2_pc1_c", 64'(out_pc1), 64'h8);
    chk("t2_insn0_c", 64'(out_insn0), 64'hffff_fff7);
    drv(1'b0, 32'h0, 1'b0, 1'b1); step();
    chk("t2_drained1", 64'(out_valid1), 64'h0);

    // Fill the skid entry while stalled, then drain.
    drv(1'b1, 32'h100, 1'b0, 1'b0); step();
    drv(1'b1, 32'h104, 1'b0, 1'b0); step();
    chk("t3_occ1_full", 64'(occ1), 64'h2);
    chk("t3_rdy1_full", 64'(in_ready1), 64'h0);
    chk("t3_pc1_head", 64'(out_pc1), 64'h100);
    chk("t3_occ0_one", 64'(occ0), 64'h1);
    drv(1'b0, 32'h0, 1'b0, 1'b0); step();
    chk("t3_pc1_stable", 64'(out_pc1), 64'h100);
    drv(1'b0, 32'h0, 1'b0, 1'b1); step();
    chk("t3_pc1_second", 64'(out_pc1), 64'h104);
    chk("t3_rdy1_back", 64'(in_ready1), 64'h1);
    step();
    chk("t3_empty1", 64'(out_valid1), 64'h0);

    // Flush while full with a word offered.
    drv(1'b1, 32'h200, 1'b0, 1'b0); step();
    drv(1'b1, 32'h204, 1'b0, 1'b0); step();
    drv(1'b1, 32'h108, 1'b1, 1'b0); #1;
    chk("t4_rdy1_flush", 64'(in_ready1), 64'h0);
    chk("t4_rdy0_flush", 64'(in_ready0), 64'h0);
    step();
    drv(1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("t4_valid1", 64'(out_valid1), 64'h0);
    chk("t4_occ1", 64'(occ1), 64'h0);
    chk("t4_insn1", 64'(out_insn1), 64'h13);
    chk("t4_rdy1_after", 64'(in_ready1), 64'h1);
    step();

    // Single entry: stall, then pop and push in the same edge.
    drv(1'b1, 32'h300, 1'b0, 1'b0); step();
    drv(1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("t5_rdy0_stall", 64'(in_ready0), 64'h0);
    drv(1'b1, 32'h304, 1'b0, 1'b1); #1;
    chk("t5_rdy0_go", 64'(in_ready0), 64'h1);
    step();
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t5_pc0_new", 64'(out_pc0), 64'h304);
    chk("t5_occ0", 64'(occ0), 64'h1);

    // Asynchronous reset with the skid instance full.
    drv(1'b1, 32'h400, 1'b0, 1'b0); step();
    drv(1'b1, 32'h404, 1'b0, 1'b0); step();
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t6_occ1_pre", 64'(occ1), 64'h2);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid1", 64'(out_valid1), 64'h0);
    chk("t6_occ1", 64'(occ1), 64'h0);
    chk("t6_rdy1", 64'(in_ready1), 64'h0);
    chk("t6_insn1", 64'(out_insn1), 64'h13);
    chk("t6_pc1", 64'(out_pc1), 64'h0);
    chk("t6_valid0", 64'(out_valid0), 64'h0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    step();

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      drv($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 55);
      in_insn = $urandom;
      step();
    end
    drv(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
